maquina_estados: RTL and testbench

//  Main control FSM, directly upstream of the four-FIFO occupancy counter stage.

---
 rtl/maquina_estados_pkg.sv | 12 +
 rtl/maquina_estados_umbrales.sv | 32 +++
 rtl/maquina_estados.sv | 65 ++++++
 tb/tb_maquina_estados.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/maquina_estados_pkg.sv
// maquina_estados_pkg: state encoding and default widths shared by the FSM, counter stage and bench
package maquina_estados_pkg;
   localparam int UMBRAL_BITS_DEF = 3;
   localparam int NUM_FIFOS_DEF = 4;
   typedef enum logic [3:0] {
      ST_RESET  = 4'b0000,
      ST_INIT   = 4'b0001,
      ST_IDLE   = 4'b0010,
      ST_ACTIVE = 4'b0100,
      ST_ERROR  = 4'b1000
   } estado_t;
endpackage

// File: rtl/maquina_estados_umbrales.sv
// registro_umbrales: threshold registers loaded during INIT
// UMBRAL_CHECK_EN enables flagging umbral_bajo_in >= umbral_alto_in as invalid.
module registro_umbrales #(
   parameter int UMBRAL_BITS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [UMBRAL_BITS-1:0] umbral_alto_in,
   input  logic [UMBRAL_BITS-1:0] umbral_bajo_in,
   output logic [UMBRAL_BITS-1:0] umbral_alto,
   output logic [UMBRAL_BITS-1:0] umbral_bajo,
   output logic                   umbral_invalido
);
   logic [UMBRAL_BITS-1:0] alto_q, bajo_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         alto_q <= '0;
         bajo_q <= '0;
      end else if (load) begin
         alto_q <= umbral_alto_in;
         bajo_q <= umbral_bajo_in;
      end
   end
   assign umbral_alto = alto_q;
   assign umbral_bajo = bajo_q;
`ifdef UMBRAL_CHECK_EN
   assign umbral_invalido = umbral_bajo_in >= umbral_alto_in;
`else
   assign umbral_invalido = 1'b0;
`endif
endmodule

// File: rtl/maquina_estados.sv
// maquina_estados: main control FSM; latches FIFO thresholds in INIT, sticky ERROR until rst.
// UMBRAL_CHECK_EN: an invalid threshold pair on INIT exit goes to ERROR instead of IDLE.
module maquina_estados
   import maquina_estados_pkg::*;
#(
   parameter int UMBRAL_BITS = UMBRAL_BITS_DEF,
   parameter int NUM_FIFOS = NUM_FIFOS_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   init,
   input  logic [UMBRAL_BITS-1:0] umbral_alto_in,
   input  logic [UMBRAL_BITS-1:0] umbral_bajo_in,
   input  logic [NUM_FIFOS-1:0]   fifo_empty,
   input  logic [NUM_FIFOS-1:0]   fifo_error,
   output logic [3:0]             estado_FSM,
   output logic                   idle,
   output logic [UMBRAL_BITS-1:0] umbral_alto,
   output logic [UMBRAL_BITS-1:0] umbral_bajo,
   output logic                   error_out,
   output logic [NUM_FIFOS-1:0]   error_mask
);
   estado_t estado_q;
   logic [NUM_FIFOS-1:0] mask_q;
   logic umbral_invalido;
   registro_umbrales #(.UMBRAL_BITS(UMBRAL_BITS)) u_umbrales (
      .clk            (clk),
      .rst            (rst),
      .load           (estado_q == ST_INIT),
      .umbral_alto_in (umbral_alto_in),
      .umbral_bajo_in (umbral_bajo_in),
      .umbral_alto    (umbral_alto),
      .umbral_bajo    (umbral_bajo),
      .umbral_invalido(umbral_invalido)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= ST_RESET;
         mask_q   <= '0;
      end else begin
         case (estado_q)
            ST_RESET: estado_q <= ST_INIT;
            ST_INIT:
               if (!init) begin
                  estado_q <= umbral_invalido ? ST_ERROR : ST_IDLE;
                  mask_q   <= '0;
               end
            ST_IDLE, ST_ACTIVE:
               if (|fifo_error) begin
                  estado_q <= ST_ERROR;
                  mask_q   <= fifo_error;
               end else if (init)
                  estado_q <= ST_INIT;
               else
                  estado_q <= (&fifo_empty) ? ST_IDLE : ST_ACTIVE;
            ST_ERROR: estado_q <= ST_ERROR;
            default:  estado_q <= ST_RESET;
         endcase
      end
   end
   assign estado_FSM = estado_q;
   assign idle       = estado_q == ST_IDLE;
   assign error_out  = estado_q == ST_ERROR;
   assign error_mask = mask_q;
endmodule

// File: tb/tb_maquina_estados.sv
// tb_maquina_estados: directed plus randomized checks against a behavioural model of the control FSM
module tb_maquina_estados;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       init = 1'b0;
   logic [2:0] umbral_alto_in = '0;
   logic [2:0] umbral_bajo_in = '0;
   logic [3:0] fifo_empty = 4'hF;
   logic [3:0] fifo_error = '0;
   logic [3:0] estado_FSM;
   logic       idle;
   logic [2:0] umbral_alto;
   logic [2:0] umbral_bajo;
   logic       error_out;
   logic [3:0] error_mask;
   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
`ifdef UMBRAL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   maquina_estados dut (
      .clk           (clk),
      .rst           (rst),
      .init          (init),
      .umbral_alto_in(umbral_alto_in),
      .umbral_bajo_in(umbral_bajo_in),
      .fifo_empty    (fifo_empty),
      .fifo_error    (fifo_error),
      .estado_FSM    (estado_FSM),
      .idle          (idle),
      .umbral_alto   (umbral_alto),
      .umbral_bajo   (umbral_bajo),
      .error_out     (error_out),
      .error_mask    (error_mask)
   );
   always #5 clk = ~clk;
   // model modes: 0 reset, 1 init, 2 idle, 3 active, 4 error; encoding is one-hot on mode-1
   int m_st = 0;
   int m_alto = 0, m_bajo = 0, m_mask = 0;
   function automatic int enc(int s);
      return (s == 0) ? 0 : (1 << (s - 1));
   endfunction
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask
   always @(posedge clk) begin
      if (rst) begin
         m_st = 0; m_alto = 0; m_bajo = 0; m_mask = 0;
      end else if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
         m_alto = int'(umbral_alto_in);
         m_bajo = int'(umbral_bajo_in);
         if (!init) begin
            if (CHK && m_bajo >= m_alto) begin
               m_st = 4; m_mask = 0;
            end else m_st = 2;
         end
      end else if (m_st == 2 || m_st == 3) begin
         if (fifo_error != 0) begin
            m_st = 4; m_mask = int'(fifo_error);
         end else if (init) m_st = 1;
         else m_st = (fifo_empty == 4'hF) ? 2 : 3;
      end
   end
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("estado_FSM", int'(estado_FSM), enc(m_st));
         chk("idle", int'(idle), int'(m_st == 2));
         chk("error_out", int'(error_out), int'(m_st == 4));
         chk("umbral_alto", int'(umbral_alto), m_alto);
         chk("umbral_bajo", int'(umbral_bajo), m_bajo);
         chk("error_mask", int'(error_mask), m_mask);
      end
   end
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask
   initial begin
      cyc();
      cmp_en = 1'b1;
      chk("t1_reset_estado", int'(estado_FSM), 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("t1_init", int'(estado_FSM), 1);
      cyc();
      chk("t1_idle", int'(estado_FSM), 2);
      chk("t1_alto0", int'(umbral_alto), 0);
      init = 1'b1; umbral_alto_in = 3'd6; umbral_bajo_in = 3'd2;
      cyc();
      chk("t2_init", int'(estado_FSM), 1);
      cyc(); cyc();
      init = 1'b0;
      cyc();
      chk("t2_idle_estado", int'(estado_FSM), 2);
      chk("t2_alto", int'(umbral_alto), 6);
      chk("t2_bajo", int'(umbral_bajo), 2);
      chk("t2_idle", int'(idle), 1);
      fifo_empty = 4'b1101;
      cyc();
      chk("t3_active", int'(estado_FSM), 4);
      fifo_empty = 4'hF;
      cyc();
      chk("t3_back_idle", int'(estado_FSM), 2);
      fifo_empty = 4'b1101;
      cyc();
      fifo_error = 4'b0100; init = 1'b1;
      cyc();
      chk("t4_error", int'(estado_FSM), 8);
      chk("t4_error_out", int'(error_out), 1);
      chk("t4_mask", int'(error_mask), 4);
      repeat (6) begin
         init = 1'($urandom); fifo_error = 4'($urandom); fifo_empty = 4'($urandom);
         cyc();
         chk("t4_sticky", int'(estado_FSM), 8);
         chk("t4_mask_hold", int'(error_mask), 4);
      end
      rst = 1'b1;
      cyc();
      chk("t4_rst", int'(estado_FSM), 0);
      chk("t4_rst_mask", int'(error_mask), 0);
      chk("t4_rst_alto", int'(umbral_alto), 0);
      rst = 1'b0; init = 1'b1; fifo_error = '0; umbral_alto_in = 3'd5; umbral_bajo_in = 3'd1;
      cyc(); cyc(); cyc();
      chk("t5_alto_loaded", int'(umbral_alto), 5);
      rst = 1'b1;
      cyc();
      chk("t5_rst_estado", int'(estado_FSM), 0);
      chk("t5_rst_alto", int'(umbral_alto), 0);
      chk("t5_rst_bajo", int'(umbral_bajo), 0);
      rst = 1'b0; umbral_alto_in = 3'd3; umbral_bajo_in = 3'd3; init = 1'b1;
      cyc(); cyc();
      init = 1'b0;
      cyc();
`ifdef UMBRAL_CHECK_EN
      chk("t6_check_error", int'(estado_FSM), 8);
      chk("t6_check_mask", int'(error_mask), 0);
      chk("t6_check_alto", int'(umbral_alto), 3);
`else
      chk("t6_nocheck_idle", int'(estado_FSM), 2);
      chk("t6_nocheck_bajo", int'(umbral_bajo), 3);
`endif
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (3000) begin
         rst = ($urandom_range(0, 99) == 0);
         init = ($urandom_range(0, 7) == 0);
         fifo_error = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'h0;
         fifo_empty = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
         umbral_alto_in = 3'($urandom);
         umbral_bajo_in = 3'($urandom);
         cyc();
      end
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
